dtlb_ptw_mem_responder: RTL
===========================

// Module: dtlb_ptw_mem_responder
// PURPOSE
//  Memory-side responder for DTLB page-table walks. Accepts single-cycle PTE fetch requests
//  (tlb_start_burst + tlb_address) from DTLB port0 and port1 walkers, issues one single-beat
//  AXI4 read per request, and returns the PTE to the requester with a one-cycle mem_ack.
//  Sits between the two DTLB port FSMs and the MMU AXI read master.
// PARAMETERS
//  AXI_ADDR_W  64  AXI read address width
//  AXI_DATA_W  64  AXI read data width; 64 or 128 only (128: 64-bit lane selected by addr[3])
//  AXI_ID      0   constant ARID driven on every request
// PORTS
//  clk                    in   1   clock
//  rst                    in   1   synchronous active-high reset
//  tlb_start_burst_port0  in   1   port0 PTE fetch request, single-cycle pulse
//  tlb_address_port0      in   64  port0 PTE physical address, valid with the pulse only
//  tlb_start_burst_port1  in   1   port1 PTE fetch request, single-cycle pulse
//  tlb_address_port1      in   64  port1 PTE physical address, valid with the pulse only
//  mem_ack_port0          out  1   port0 PTE returned, one-cycle pulse
//  mem_ack_port1          out  1   port1 PTE returned, one-cycle pulse
//  write_data_axi         out  64  returned PTE, shared by both ports, valid with mem_ack_*
//  m_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  ID,AXI_ADDR_W,8,3,2,1  AR channel
//  m_axi_arready          in   1   AR channel ready
//  m_axi_rid/rdata/rresp/rlast/rvalid  in  ID,AXI_DATA_W,2,1,1  R channel
//  m_axi_rready           out  1   R channel ready
//  mem_err_port0/1        out  1   (PTW_RESP_ERR_EN only) bus error, pulses with mem_ack_*
// BEHAVIOUR
//  - Reset: all outputs 0, write_data_axi 0, FSM IDLE, both pending slots empty.
//  - Pending slots: one per port (valid + 64b addr); set on start pulse in any state,
//    cleared when that port's fetch enters AR. Pulse while own slot full: slot overwritten.
//  - FSM IDLE -> AR when any slot valid; port1 wins if both valid (port1 takes over the bus).
//    Request captured into owner reg + araddr = {addr[63:3],3'b000} on IDLE->AR edge.
//  - AR: arvalid=1, arlen=0, arsize=3'b011, arburst=2'b01 (INCR); araddr/arid stable while
//    arvalid && !arready. Handshake -> R.
//  - R: rready=1; on rvalid: capture data lane (addr[3] when AXI_DATA_W=128) -> ACK. rlast
//    ignored (single beat); rid not checked.
//  - ACK: mem_ack_<owner>=1 for exactly 1 cycle, write_data_axi valid; -> IDLE, or directly
//    -> AR if other slot valid (back-to-back). write_data_axi held until next ACK.
//  - Latency (arready, rvalid immediate): pulse at cycle 0 -> arvalid cycle 1 -> R cycle 2
//    -> mem_ack cycle 3 (same-cycle start+IDLE: slot bypass allowed, not required).
//  - Aborts: requester-side only; an issued fetch always completes and acks.
//  - Start pulse on same port while its fetch is in flight: queued in slot, served after ACK.
//  - Simultaneous start pulses: both slots set; port1 served first, port0 after ACK.
//  - rst mid-transaction: FSM/slots cleared next edge; outstanding AXI beat is system's problem.
// CONFIGURATION
//  PTW_RESP_ERR_EN defined: rresp!=2'b00 -> write_data_axi forced 0 (V=0), mem_err_<owner>
//    pulses with mem_ack_<owner>. Undefined: rresp ignored, rdata forwarded, no mem_err ports.
// TESTING
//  - port1 pulse addr 0x8000_1238, arready/rvalid immediate, rdata 0x2000_04CF -> araddr
//    0x8000_1238 cycle 1, mem_ack_port1 cycle 3, write_data_axi 0x2000_04CF, port0 silent.
//  - both pulses same cycle (p0 0x100, p1 0x200) -> AR 0x200 first, ack p1, then AR 0x100
//    immediately after ACK, ack p0; exactly one ack each.
//  - arready low 5 cycles -> arvalid held 6 cycles, araddr stable; rvalid delayed 4 -> 1 ack.
//  - AXI_DATA_W=128, addr 0x...08, rdata hi=0xAAAA lo=0x5555 -> write_data_axi 0xAAAA.
//  - rresp=2'b10 with PTW_RESP_ERR_EN -> write_data_axi 0, mem_err_port0 with mem_ack_port0.
//  - rst asserted in R state -> next cycle all outputs 0, IDLE; new pulse served normally.

Source files
------------

// File: rtl/dtlb_ptw_mem_responder_if.sv
// AXI4 read-channel bundle between the DTLB PTE responder (master) and the MMU read port (slave).
interface dtlb_ptw_mem_responder_if #(
    parameter int AXI_ADDR_W = 64,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4
);
    logic [AXI_ID_W-1:0]   m_axi_arid;
    logic [AXI_ADDR_W-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [AXI_ID_W-1:0]   m_axi_rid;
    logic [AXI_DATA_W-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );
endinterface

// File: rtl/dtlb_ptw_mem_responder.sv
// Serves DTLB port0/port1 PTE fetches as single-beat AXI4 reads, port1 having priority.
// Optional macro PTW_RESP_ERR_EN: AXI error responses zero the PTE and pulse mem_err_<owner>.
module dtlb_ptw_mem_responder #(
    parameter int AXI_ADDR_W = 64,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W   = 4,
    parameter logic [AXI_ID_W-1:0] AXI_ID = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tlb_start_burst_port0,
    input  logic [63:0] tlb_address_port0,
    input  logic        tlb_start_burst_port1,
    input  logic [63:0] tlb_address_port1,
    output logic        mem_ack_port0,
    output logic        mem_ack_port1,
    output logic [63:0] write_data_axi,
`ifdef PTW_RESP_ERR_EN
    output logic        mem_err_port0,
    output logic        mem_err_port1,
`endif
    dtlb_ptw_mem_responder_if.master axi
);
    typedef enum logic [1:0] {IDLE, AR, R, ACK} state_t;

    state_t                state;
    logic                  slot_v0, slot_v1;
    logic [63:0]           slot_a0, slot_a1;
    logic                  owner;
    logic                  lane_hi;
    logic                  arvalid_q, rready_q;
    logic [AXI_ADDR_W-1:0] araddr_q;

    logic        pend0, pend1, launch, launch_port;
    logic [63:0] launch_addr, launch_aligned;
    logic [63:0] rlane;

    // A pulse arriving this cycle counts as pending, so an idle responder issues it at once.
    always_comb begin
        pend0       = slot_v0 | tlb_start_burst_port0;
        pend1       = slot_v1 | tlb_start_burst_port1;
        launch      = ((state == IDLE) || (state == ACK)) && (pend0 || pend1);
        launch_port = pend1;
        if (pend1)
            launch_addr = tlb_start_burst_port1 ? tlb_address_port1 : slot_a1;
        else
            launch_addr = tlb_start_burst_port0 ? tlb_address_port0 : slot_a0;
        launch_aligned = {launch_addr[63:3], 3'b000};
    end

    generate
        if (AXI_DATA_W == 128) begin : g_wide
            assign rlane = lane_hi ? axi.m_axi_rdata[127:64] : axi.m_axi_rdata[63:0];
        end else begin : g_narrow
            assign rlane = axi.m_axi_rdata[63:0];
        end
    endgenerate

    assign axi.m_axi_arvalid = arvalid_q;
    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arid    = arvalid_q ? AXI_ID : '0;
    assign axi.m_axi_arlen   = 8'd0;
    assign axi.m_axi_arsize  = arvalid_q ? 3'b011 : 3'b000;
    assign axi.m_axi_arburst = arvalid_q ? 2'b01 : 2'b00;
    assign axi.m_axi_rready  = rready_q;

    // Single beat only, so rid/rlast carry no information for this responder.
    logic unused_sigs;
    assign unused_sigs = ^{axi.m_axi_rid, axi.m_axi_rlast, axi.m_axi_rresp, lane_hi,
                           launch_addr[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            slot_v0        <= 1'b0;
            slot_v1        <= 1'b0;
            slot_a0        <= '0;
            slot_a1        <= '0;
            owner          <= 1'b0;
            lane_hi        <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            araddr_q       <= '0;
            mem_ack_port0  <= 1'b0;
            mem_ack_port1  <= 1'b0;
            write_data_axi <= '0;
`ifdef PTW_RESP_ERR_EN
            mem_err_port0  <= 1'b0;
            mem_err_port1  <= 1'b0;
`endif
        end else begin
            mem_ack_port0 <= 1'b0;
            mem_ack_port1 <= 1'b0;
`ifdef PTW_RESP_ERR_EN
            mem_err_port0 <= 1'b0;
            mem_err_port1 <= 1'b0;
`endif
            if (tlb_start_burst_port0) slot_a0 <= tlb_address_port0;
            if (tlb_start_burst_port1) slot_a1 <= tlb_address_port1;

            // The launching port's slot is consumed, including a pulse arriving this cycle.
            if (launch && !launch_port)      slot_v0 <= 1'b0;
            else if (tlb_start_burst_port0)  slot_v0 <= 1'b1;
            if (launch && launch_port)       slot_v1 <= 1'b0;
            else if (tlb_start_burst_port1)  slot_v1 <= 1'b1;

            case (state)
                AR: if (axi.m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= R;
                end
                R: if (axi.m_axi_rvalid) begin
                    rready_q      <= 1'b0;
                    mem_ack_port0 <= !owner;
                    mem_ack_port1 <= owner;
`ifdef PTW_RESP_ERR_EN
                    write_data_axi <= (axi.m_axi_rresp != 2'b00) ? 64'd0 : rlane;
                    mem_err_port0  <= (axi.m_axi_rresp != 2'b00) && !owner;
                    mem_err_port1  <= (axi.m_axi_rresp != 2'b00) && owner;
`else
                    write_data_axi <= rlane;
`endif
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase

            if (launch) begin
                owner     <= launch_port;
                lane_hi   <= launch_addr[3];
                araddr_q  <= launch_aligned[AXI_ADDR_W-1:0];
                arvalid_q <= 1'b1;
                state     <= AR;
            end
        end
    end
endmodule
